// File: rtl/nes_poll_scheduler.sv
// Shared NES controller bus sequencer: polls two pads in parallel and
// publishes registered, active-high button vectors with a valid strobe.
module nes_poll_scheduler #(
    parameter int LATCH_CYCLES = 300,
    parameter int HALF_CYCLES  = 150,
    parameter int POLL_PERIOD  = 416667
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       poll_req,
    input  logic       nes_data_p1,
    input  logic       nes_data_p2,
    output logic       nes_latch,
    output logic       nes_pulse,
    output logic [7:0] buttons_p1,
    output logic [7:0] buttons_p2,
    output logic       valid,
    output logic       busy
);
    localparam int MAXC = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int DW   = $clog2(MAXC) + 1;
    localparam int TW   = $clog2(POLL_PERIOD);

    localparam logic [DW-1:0] LATCH_LAST = DW'(LATCH_CYCLES - 1);
    localparam logic [DW-1:0] HALF_LAST  = DW'(HALF_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SETTLE,
        PULSE_HI,
        DONE
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] dly, dly_nxt;
    logic [2:0]    bit_cnt, bit_nxt;
    logic [7:0]    sr1, sr1_nxt;
    logic [7:0]    sr2, sr2_nxt;
    logic [TW-1:0] timer;
    logic          pending;
    logic          clr_pending;
    logic          wrap;
    logic [1:0]    sync1, sync2;

    assign wrap = (timer == TIMER_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
            timer <= '0;
        end else begin
            sync1 <= {sync1[0], nes_data_p1};
            sync2 <= {sync2[0], nes_data_p2};
            timer <= wrap ? '0 : timer + TW'(1);
        end
    end

    // A request landing on the launch cycle survives so it gets its own poll.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pending <= 1'b0;
        else if (!enable)
            pending <= 1'b0;
        else if (wrap || poll_req)
            pending <= 1'b1;
        else if (clr_pending)
            pending <= 1'b0;
    end

    always_comb begin
        state_nxt   = state;
        dly_nxt     = dly;
        bit_nxt     = bit_cnt;
        sr1_nxt     = sr1;
        sr2_nxt     = sr2;
        clr_pending = 1'b0;
        unique case (state)
            IDLE: begin
                if (pending && enable) begin
                    state_nxt   = LATCH;
                    dly_nxt     = '0;
                    bit_nxt     = '0;
                    clr_pending = 1'b1;
                end
            end
            LATCH: begin
                if (dly == LATCH_LAST) begin
                    state_nxt = SETTLE;
                    dly_nxt   = '0;
                end else begin
                    dly_nxt = dly + DW'(1);
                end
            end
            SETTLE: begin
                if (dly == HALF_LAST) begin
                    dly_nxt          = '0;
                    sr1_nxt[bit_cnt] = ~sync1[1];
                    sr2_nxt[bit_cnt] = ~sync2[1];
                    if (bit_cnt == 3'd7) begin
                        state_nxt = DONE;
                    end else begin
                        bit_nxt   = bit_cnt + 3'd1;
                        state_nxt = PULSE_HI;
                    end
                end else begin
                    dly_nxt = dly + DW'(1);
                end
            end
            PULSE_HI: begin
                if (dly == HALF_LAST) begin
                    state_nxt = SETTLE;
                    dly_nxt   = '0;
                end else begin
                    dly_nxt = dly + DW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            dly        <= '0;
            bit_cnt    <= '0;
            sr1        <= '0;
            sr2        <= '0;
            nes_latch  <= 1'b0;
            nes_pulse  <= 1'b0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            buttons_p1 <= '0;
            buttons_p2 <= '0;
        end else begin
            state     <= state_nxt;
            dly       <= dly_nxt;
            bit_cnt   <= bit_nxt;
            sr1       <= sr1_nxt;
            sr2       <= sr2_nxt;
            nes_latch <= (state_nxt == LATCH);
            nes_pulse <= (state_nxt == PULSE_HI);
            valid     <= (state_nxt == DONE);
            busy      <= (state_nxt != IDLE);
            if (state_nxt == DONE) begin
                buttons_p1 <= sr1_nxt;
                buttons_p2 <= sr2_nxt;
            end
        end
    end
endmodule

// File: tb/tb_nes_poll_scheduler.sv
// Scoreboard bench for nes_poll_scheduler with pad models on the bus.
module tb_nes_poll_scheduler;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b1;
    logic       poll_req = 1'b0;
    logic       nes_data_p1;
    logic       nes_data_p2;
    logic       nes_latch;
    logic       nes_pulse;
    logic [7:0] buttons_p1;
    logic [7:0] buttons_p2;
    logic       valid;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int edges = 0;

    logic [7:0]  press1 = 8'h81;
    logic [7:0]  press2 = 8'h00;
    logic        p2_force0 = 1'b0;
    logic [3:0]  idx = 4'd0;
    logic [15:0] exp_q[$];

    nes_poll_scheduler #(
        .LATCH_CYCLES(4),
        .HALF_CYCLES(2),
        .POLL_PERIOD(100)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .poll_req(poll_req),
        .nes_data_p1(nes_data_p1),
        .nes_data_p2(nes_data_p2),
        .nes_latch(nes_latch),
        .nes_pulse(nes_pulse),
        .buttons_p1(buttons_p1),
        .buttons_p2(buttons_p2),
        .valid(valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n)
        if (!reset_n) edges = 0;
        else edges = edges + 1;

    // Pad model: latch reloads bit 0, each pulse rise advances one bit.
    always @(posedge nes_latch or posedge nes_pulse)
        if (nes_latch) idx = 4'd0;
        else if (idx < 4'd8) idx = idx + 4'd1;

    assign nes_data_p1 = (idx < 4'd8) ? ~press1[idx[2:0]] : 1'b1;
    assign nes_data_p2 = p2_force0 ? 1'b0 :
                         (idx < 4'd8) ? ~press2[idx[2:0]] : 1'b1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: waveform shape per poll plus scoreboard pop on valid.
    int         cyc = 0;
    int         t0 = 0;
    int         latch_len = 0;
    int         npulse = 0;
    int         pw = 0;
    logic       pw_bad = 1'b0;
    logic       prev_latch = 1'b0;
    logic       prev_pulse = 1'b0;
    logic       prev_valid = 1'b0;
    logic [15:0] prev_btn = 16'h0;
    logic [15:0] e;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_latch = 1'b0;
            prev_pulse = 1'b0;
            prev_valid = 1'b0;
            prev_btn   = 16'h0;
            pw         = 0;
        end else begin
            cyc++;
            if (nes_latch && !prev_latch) begin
                t0 = cyc;
                latch_len = 0;
                npulse = 0;
                pw = 0;
                pw_bad = 1'b0;
            end
            if (nes_latch) latch_len++;
            if (nes_pulse) pw++;
            if (nes_pulse && !prev_pulse) npulse++;
            if (!nes_pulse && prev_pulse) begin
                if (pw != 2) pw_bad = 1'b1;
                pw = 0;
            end
            if (!valid && {buttons_p1, buttons_p2} != prev_btn)
                chk("buttons_hold", {buttons_p1, buttons_p2}, prev_btn);
            if (valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("buttons", {buttons_p1, buttons_p2}, e);
                end
                chk("latency", cyc - t0, 34);
                chk("latch_len", latch_len, 4);
                chk("pulse_count", npulse, 7);
                chk("pulse_width_bad", pw_bad, 0);
                chk("valid_one_cycle", prev_valid, 0);
                chk("busy_at_valid", busy, 1);
            end
            prev_latch = nes_latch;
            prev_pulse = nes_pulse;
            prev_valid = valid;
            prev_btn   = {buttons_p1, buttons_p2};
        end
    end

    task automatic wait_latch(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!nes_latch && n < 400);
        if (!nes_latch) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid && n < 400);
        if (!valid) chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int vedge;
        int nf;
        int nr;
        logic pp;
        logic bad;

        repeat (3) @(negedge clk);
        chk("rst_latch", nes_latch, 0);
        chk("rst_pulse", nes_pulse, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_buttons", {buttons_p1, buttons_p2}, 16'h0);

        exp_q.push_back(16'h8100);
        exp_q.push_back(16'h8100);
        exp_q.push_back(16'h8100);
        reset_n = 1'b1;

        bad = 1'b0;
        do begin
            @(negedge clk);
            if (nes_latch || nes_pulse || busy || valid) bad = 1'b1;
        end while (edges < 100);
        chk("idle_outputs_zero", bad, 0);
        wait_latch("first_latch");
        chk("first_latch_edge", edges, 101);

        repeat (10) @(negedge clk);
        poll_req = 1'b1;
        @(negedge clk);
        poll_req = 1'b0;
        repeat (10) @(negedge clk);
        poll_req = 1'b1;
        @(negedge clk);
        poll_req = 1'b0;

        wait_valid("poll1_valid");
        vedge = edges;
        wait_latch("b2b_latch");
        chk("b2b_gap", edges - vedge, 2);
        wait_valid("poll2_valid");

        bad = 1'b0;
        while (edges < 199) begin
            @(negedge clk);
            if (nes_latch) bad = 1'b1;
        end
        chk("single_extra_poll", bad, 0);
        wait_valid("auto_valid");
        chk("auto_valid_edge", edges, 235);

        enable = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (i == 100) poll_req = 1'b1;
            if (i == 101) poll_req = 1'b0;
            @(negedge clk);
            if (nes_latch || nes_pulse || valid) bad = 1'b1;
        end
        chk("disabled_quiet", bad, 0);
        chk("disabled_buttons", {buttons_p1, buttons_p2}, 16'h8100);

        press1 = 8'hFF;
        press2 = 8'hFF;
        exp_q.push_back(16'hFFFF);
        vedge = edges;
        enable = 1'b1;
        wait_latch("reenable_latch");
        chk("reenable_latch_edge", edges, 601);
        wait_valid("allpress_valid");

        repeat (2) @(negedge clk);
        poll_req = 1'b1;
        @(negedge clk);
        poll_req = 1'b0;
        nr = 0;
        pp = 1'b0;
        for (int i = 0; i < 100 && nr < 3; i++) begin
            @(negedge clk);
            if (nes_pulse && !pp) nr++;
            pp = nes_pulse;
        end
        chk("pulse_before_reset", nes_pulse, 1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_outputs",
            {nes_latch, nes_pulse, valid, busy, buttons_p1, buttons_p2},
            {4'b0000, 16'h0000});
        repeat (3) @(negedge clk);
        press1 = 8'h00;
        press2 = 8'h00;
        reset_n = 1'b1;

        wait_latch("post_reset_latch");
        chk("post_reset_latch_edge", edges, 101);
        exp_q.push_back(16'h00F0);
        nf = 0;
        pp = 1'b0;
        for (int i = 0; i < 100 && nf < 3; i++) begin
            @(negedge clk);
            if (!nes_pulse && pp) nf++;
            pp = nes_pulse;
        end
        p2_force0 = 1'b1;
        wait_valid("toggle_valid");
        p2_force0 = 1'b0;

        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nes_poll_scheduler.md
# nes_poll_scheduler

Sequencer that owns the shared NES controller bus (latch and pulse lines) and polls two controllers in parallel, one data line each. It starts a read at a fixed frame rate or on request, and generates the latch and clock waveform from cycle-count parameters. It shifts in eight serial bits per player and publishes registered, active-high button vectors with a one-cycle valid strobe. It sits between the board-level NES connectors and the pong game logic, which consumes `buttons_p1`/`buttons_p2`.

## Interface
- `LATCH_CYCLES`, default 300: clk cycles `nes_latch` is held high (12 µs at 25 MHz); minimum 1.
- `HALF_CYCLES`, default 150: clk cycles per pulse half-period and per settle phase (6 µs); minimum 1.
- `POLL_PERIOD`, default 416667: clk cycles between automatic polls (60 Hz); must exceed LATCH_CYCLES + 15·HALF_CYCLES + 2.

- `clk` input, 1 bit: system clock.
- `reset_n` input, 1 bit: reset; one clock, reset is asynchronous and active-low.
- `enable` input, 1 bit: permits new polls to start.
- `poll_req` input, 1 bit: single-cycle request for an immediate poll.
- `nes_data_p1` input, 1 bit: player 1 serial data, asynchronous, active-low (0 = pressed).
- `nes_data_p2` input, 1 bit: player 2 serial data, same as p1.
- `nes_latch` output, 1 bit: shared latch to both controllers, registered.
- `nes_pulse` output, 1 bit: shared clock to both controllers, registered.
- `buttons_p1` output, 8 bits: player 1 buttons, active-high; bit order [0]=A, [1]=B, [2]=Select, [3]=Start, [4]=Up, [5]=Down, [6]=Left, [7]=Right.
- `buttons_p2` output, 8 bits: player 2 buttons, same bit order.
- `valid` output, 1 bit: one-cycle strobe; both button vectors were updated on this cycle.
- `busy` output, 1 bit: high in every state except IDLE.

## Operation
- Data inputs pass through 2-flop synchronizers; all sampling uses the synchronized value.
- Period timer: free-running, counts 0..POLL_PERIOD-1 and wraps. It runs regardless of `enable` and state.
- `pending` flag:
  - Set on the timer wrap cycle or on `poll_req`=1.
  - Cleared on the IDLE→LATCH transition.
  - Forced to 0 while `enable`=0; requests made while disabled are dropped.
- A request arriving while busy stays pending and starts the next poll immediately after DONE.
- States:
  - IDLE: latch=0, pulse=0. If `pending` and `enable` → LATCH; delay counter reset.
  - LATCH: latch=1 for LATCH_CYCLES cycles → SETTLE.
  - SETTLE: latch=0, pulse=0 for HALF_CYCLES cycles. On its last cycle, shift the inverted synchronized data of each player into that player's shift register at index `bit_cnt`.
    - If `bit_cnt`=7 → DONE.
    - Otherwise `bit_cnt`++ → PULSE_HI.
  - PULSE_HI: pulse=1 for HALF_CYCLES cycles → SETTLE.
  - DONE: one cycle; `valid`=1 → IDLE.
- `buttons_p1`/`buttons_p2` load from the shift registers on the edge entering DONE and hold until the next DONE.
- Deasserting `enable` mid-poll does not abort it; the poll completes and publishes normally.
- Delay counter width is ceil(log2(max(LATCH_CYCLES, HALF_CYCLES)))+1. `bit_cnt` is 3 bits.

## Timing
- Reset values: `nes_latch`=0, `nes_pulse`=0, `buttons_p1`=8'h00, `buttons_p2`=8'h00, `valid`=0, `busy`=0. Internally, state=IDLE, `pending`=0, timer=0, `bit_cnt`=0, synchronizers=1.
- Reset asserted mid-poll clears all outputs immediately, without waiting for a clock edge; no `valid` is issued for the aborted poll.
- Request to latch rise: `nes_latch` and `busy` rise 1 cycle after `pending` is set.
- Timer wrap: `pending` is set on the edge at timer count POLL_PERIOD-1. First automatic latch rise is at edge POLL_PERIOD+1 after reset release.
- Waveform: exactly 7 pulse-high windows, each HALF_CYCLES long, and 8 SETTLE windows.
- Poll latency: `valid` is high exactly LATCH_CYCLES + 15·HALF_CYCLES cycles after `nes_latch` first goes high.
- Back-to-back polls: the next `nes_latch` rise comes 2 cycles after the `valid` cycle (DONE→IDLE→LATCH).
- Controller data must be stable for ≥3 clk cycles before the SETTLE sample edge; a full HALF_CYCLES window covers this.

## Test plan
Parameters: LATCH_CYCLES=4, HALF_CYCLES=2, POLL_PERIOD=100.
- Reset, then idle with `enable`=1 → all outputs 0 until the first poll. `nes_latch` high for exactly 4 cycles, 7 `nes_pulse` highs of 2 cycles each, `valid` one cycle, 34 cycles after latch rise.
- Controller models: p1 drives 0 on the A and Right bit slots, p2 drives all 1 → `buttons_p1`=8'h81, `buttons_p2`=8'h00 at `valid`, held until the next `valid`.
- `poll_req` pulsed mid-poll → current poll finishes; next `nes_latch` rise 2 cycles after `valid`. A second `poll_req` during the same poll yields only one extra poll.
- `enable`=0 for 300 cycles, including a `poll_req` → `nes_latch` and `nes_pulse` stay 0, `valid` never asserts, buttons unchanged. Re-enable → next poll starts only at the following timer wrap.
- `reset_n` driven low during the 3rd PULSE_HI → outputs 0 immediately, with no clock edge required. After release, no `valid` until a new full poll completes.
- Both data lines held 0 → both vectors 8'hFF. Toggle p2 data asynchronously mid-SETTLE, away from the sample edge → value sampled at the last SETTLE cycle is captured.
